// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer_bank peripheral: channel modes, register offsets, CTRL layout.
// TIMER_BANK_PWM_EN selects whether mode 2 decodes as PWM or falls back to periodic.
package timer_bank_pkg;

    typedef enum logic [1:0] {
        TB_ONESHOT  = 2'd0,
        TB_PERIODIC = 2'd1,
        TB_PWM      = 2'd2
    } tb_mode_e;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_LOAD  = 2'd1;
    localparam logic [1:0] REG_CMP   = 2'd2;
    localparam logic [1:0] REG_COUNT = 2'd3;

    localparam int CTRL_MODE_LSB = 0;
    localparam int CTRL_EN       = 2;
    localparam int CTRL_IRQ_EN   = 3;
    localparam int CTRL_PEND     = 8;

    // Mode 3 is reserved and behaves as periodic, as does mode 2 without PWM support.
    function automatic tb_mode_e decode_mode(input logic [1:0] mode);
        case (mode)
            2'd0: return TB_ONESHOT;
`ifdef TIMER_BANK_PWM_EN
            2'd2: return TB_PWM;
`endif
            default: return TB_PERIODIC;
        endcase
    endfunction

endpackage

// File: rtl/timer_bank_ch.sv
// One timer_bank channel: tick edge detect, down-counter, LOAD/CMP/CTRL, pending and waveform.
// CMP storage and the PWM comparator exist only when TIMER_BANK_PWM_EN is defined.
module timer_bank_ch
    import timer_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_in,
    input  logic             ctrl_we,
    input  logic             load_we,
    input  logic             cmp_we,
    input  logic             count_we,
    input  logic [3:0]       ctrl_wdata,
    input  logic [WIDTH-1:0] wdata,
    output logic [31:0]      ctrl_rd,
    output logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] cmp,
    output logic [WIDTH-1:0] count,
    output logic             ch_out,
    output logic             irq_req
);

    logic [1:0]       mode_q;
    logic             en_q;
    logic             irq_en_q;
    logic             pend_q;
    logic             out_q;
    logic             tick_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] load_q;
    tb_mode_e         cur_mode;
    logic             tick;
    logic             start;
    logic             run;

    assign tick     = tick_in & ~tick_q;
    assign cur_mode = decode_mode(mode_q);
    // A 0->1 enable reloads COUNT and swallows that cycle's tick; a disabling write freezes at once.
    assign start    = ctrl_we & ctrl_wdata[CTRL_EN] & ~en_q;
    assign run      = en_q & ~(ctrl_we & ~ctrl_wdata[CTRL_EN]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= 2'd0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            pend_q   <= 1'b0;
            out_q    <= 1'b0;
            tick_q   <= 1'b0;
            count_q  <= '0;
            load_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments here; later statements override earlier ones for the
            // same register, which is how expiry beats a pending-clear and a one-shot enable write.
            tick_q <= tick_in;
            if (load_we) load_q <= wdata;
            if (count_we) pend_q <= 1'b0;
            if (ctrl_we) begin
                mode_q   <= ctrl_wdata[CTRL_MODE_LSB +: 2];
                en_q     <= ctrl_wdata[CTRL_EN];
                irq_en_q <= ctrl_wdata[CTRL_IRQ_EN];
            end
            if (start) begin
                count_q <= load_q;
                if (decode_mode(ctrl_wdata[CTRL_MODE_LSB +: 2]) == TB_ONESHOT) out_q <= 1'b0;
            end else if (run && tick) begin
                if (count_q != '0) begin
                    count_q <= count_q - WIDTH'(1);
                end else begin
                    pend_q <= 1'b1;
                    case (cur_mode)
                        TB_ONESHOT: begin
                            en_q  <= 1'b0;
                            out_q <= 1'b1;
                        end
                        TB_PWM: count_q <= load_q;
                        default: begin
                            count_q <= load_q;
                            out_q   <= ~out_q;
                        end
                    endcase
                end
            end
        end
    end

`ifdef TIMER_BANK_PWM_EN
    logic [WIDTH-1:0] cmp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cmp_q <= '0;
        else if (cmp_we) cmp_q <= wdata;
    end

    assign cmp    = cmp_q;
    assign ch_out = (cur_mode == TB_PWM) ? (en_q & (count_q < cmp_q)) : out_q;
`else
    logic unused_cmp_we;

    assign unused_cmp_we = cmp_we;
    assign cmp           = '0;
    assign ch_out        = out_q;
`endif

    always_comb begin
        // NOTE: default first so every bit is assigned on every path and no latch is inferred.
        ctrl_rd                           = '0;
        ctrl_rd[CTRL_MODE_LSB +: 2]       = mode_q;
        ctrl_rd[CTRL_EN]                  = en_q;
        ctrl_rd[CTRL_IRQ_EN]              = irq_en_q;
        ctrl_rd[CTRL_PEND]                = pend_q;
    end

    assign load    = load_q;
    assign count   = count_q;
    assign irq_req = pend_q & irq_en_q;

endmodule

// File: rtl/timer_bank.sv
// timer_bank: NUM_CH memory-mapped down-counter channels with a combined interrupt on the MIO bus.
// Build with TIMER_BANK_PWM_EN defined to include PWM mode and the CMP registers.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int  NUM_CH = 3,
    parameter int  WIDTH  = 32,
    localparam int AW     = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] tick_in,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] ch_out,
    output logic              irq
);

    logic [AW-1:0]    ch_idx;
    logic [1:0]       reg_sel;
    logic             ch_ok;
    logic [31:0]      ctrl_rd  [NUM_CH];
    logic [WIDTH-1:0] load_rd  [NUM_CH];
    logic [WIDTH-1:0] cmp_rd   [NUM_CH];
    logic [WIDTH-1:0] count_rd [NUM_CH];
    logic [NUM_CH-1:0] irq_req;
    logic [31:0]      rd_next;

    // Channel index kept at full address width so out-of-range channels compare cleanly.
    assign ch_idx  = addr >> 2;
    assign reg_sel = addr[1:0];
    assign ch_ok   = ch_idx < AW'(NUM_CH);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic sel;

        assign sel = we & ch_ok & (ch_idx == AW'(g));

        timer_bank_ch #(.WIDTH(WIDTH)) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick_in   (tick_in[g]),
            .ctrl_we   (sel && reg_sel == REG_CTRL),
            .load_we   (sel && reg_sel == REG_LOAD),
            .cmp_we    (sel && reg_sel == REG_CMP),
            .count_we  (sel && reg_sel == REG_COUNT),
            .ctrl_wdata(wdata[3:0]),
            .wdata     (wdata[WIDTH-1:0]),
            .ctrl_rd   (ctrl_rd[g]),
            .load      (load_rd[g]),
            .cmp       (cmp_rd[g]),
            .count     (count_rd[g]),
            .ch_out    (ch_out[g]),
            .irq_req   (irq_req[g])
        );
    end

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_ok && ch_idx == AW'(i)) begin
                case (reg_sel)
                    REG_CTRL: rd_next = ctrl_rd[i];
                    REG_LOAD: rd_next = 32'(load_rd[i]);
                    REG_CMP:  rd_next = 32'(cmp_rd[i]);
                    default:  rd_next = 32'(count_rd[i]);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else rdata <= rd_next;
    end

    assign irq = |irq_req;

endmodule
